dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Arbiter and sequencer for the single data-memory port shared by the load path and the retired-store path. Retired stores go into an internal write buffer and drain to memory in the background, and loads are issued one at a time. The arbiter blocks any load that aliases a buffered store and keeps either requester from starving the other. It sits between the load/store queue and the data memory.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width
- WB_DEPTH, 8, write-buffer entries (power of two, ≥2)
- WB_HIGH, 6, occupancy at or above which stores take priority (1..WB_DEPTH)
- MAX_LD_BURST, 4, consecutive load grants allowed while the buffer is non-empty

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  pipeline flush; cancels the in-flight/pending load, keeps the write buffer
- st_valid  in  1  retired store push
- st_addr  in  ADDR_WIDTH  store address
- st_wdata  in  DATA_WIDTH  store data
- st_ready  out  1  buffer can accept (= !wb_full)
- ld_req  in  1  load request, held until accepted
- ld_addr  in  ADDR_WIDTH  load address
- ld_ready  out  1  load accepted and issued this cycle
- ld_rvalid  out  1  load data valid
- ld_rdata  out  DATA_WIDTH  raw memory word (extension is done by the requester)
- mem_en  out  1  memory access this cycle
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_WIDTH  access address
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data
- mem_rvalid  in  1  read response, ≥1 cycle after the read issue
- wb_count  out  $clog2(WB_DEPTH)+1  write-buffer occupancy
- wb_empty  out  1  buffer empty (used as the fence/drain indicator)

## Operation
- Write buffer: circular FIFO with head and tail pointers and a count.
  - Push when st_valid && st_ready. Pushes beyond that are a requester error and are dropped.
  - Pop when a store is granted. Push and pop in the same cycle leave the count unchanged.
  - st_ready depends only on the registered count; it does not look ahead to a same-cycle pop.
- Hazard: asserted when ld_addr[ADDR_WIDTH-1:2] equals the word address of any valid buffer entry. A hazarded load is not granted.
- FSM states:
  - IDLE: at most one grant per cycle.
  - RD_WAIT: a read is outstanding. No grants. mem_rvalid → IDLE.
  - RD_DROP: a flushed read is outstanding. No grants. mem_rvalid → IDLE, and the response is discarded.
- Grant rule in IDLE, in priority order:
  1. Store, if wb_count ≥ WB_HIGH, or hazard, or ld_streak == MAX_LD_BURST.
  2. Otherwise load, if ld_req && !flush. Go to RD_WAIT.
  3. Otherwise store, if the buffer is non-empty.
  4. Otherwise idle.
- ld_streak:
  - Increments on each load grant while the buffer is non-empty.
  - Clears on a store grant or when the buffer is empty.
  - Saturates at MAX_LD_BURST.
- Memory outputs are combinational from state, buffer head and load inputs:
  - Store grant: mem_en=1, mem_we=1, mem_addr/mem_wdata = head entry.
  - Load grant: mem_en=1, mem_we=0, mem_addr=ld_addr, ld_ready=1.
  - Otherwise all memory outputs are 0.
- ld_rvalid = mem_rvalid && state==RD_WAIT && !flush. ld_rdata = mem_rdata when ld_rvalid, else 0.
- Flush:
  - In RD_WAIT: go to RD_DROP, or straight to IDLE if mem_rvalid is high that cycle. The response is suppressed either way.
  - In IDLE: no load is granted; store grants proceed.
  - Buffer contents and the store drain are never affected.
- mem_rvalid while in IDLE is ignored.
- Reset (at any time, including mid-read): state=IDLE, buffer empty, pointers and ld_streak = 0. While rst is high all outputs are 0 except wb_empty=1. A read outstanding across reset is ignored when it returns.

## Timing
- Load issue is zero-latency: a request accepted in cycle T drives mem_en in cycle T.
- Load response: ld_rvalid in the same cycle as mem_rvalid. Total latency = memory latency.
- Store: pushed at edge T, eligible for issue in cycle T+1. There is no same-cycle bypass.
- Maximum throughput is one write per cycle, or one read per memory round-trip. Reads and writes never overlap.
- Status outputs: wb_count and wb_empty are registered; st_ready is derived from the registered count.

## Test plan
- Store drain: push 3 stores (0x100/0xA, 0x104/0xB, 0x108/0xC), no loads → 3 consecutive writes in order starting the cycle after the first push; wb_empty=1 afterwards.
- Load with 2-cycle memory: ld_req 0x200, memory returns 0xDEADBEEF → ld_ready in cycle T, ld_rvalid with data 0xDEADBEEF at T+2, no grant in between.
- Hazard: buffer holds 0x300, ld_req 0x302 → the store to 0x300 is written first, then the load issues the next cycle.
- Full / priority / starvation:
  - Fill 8 stores with st_ready dropping at count 8; further pushes are dropped.
  - With wb_count ≥ 6, stores win over a concurrent load.
  - With count 1 and a continuous load stream, the store is granted after 4 loads.
- Flush: assert flush during RD_WAIT, memory responds 3 cycles later → ld_rvalid stays 0, state returns to IDLE; the buffered store 0x400 still drains.
- Reset: assert rst mid-read with 2 stores buffered → all outputs 0, wb_count=0; a late mem_rvalid after reset produces no ld_rvalid.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//
// Shares the single data-memory port between the load path and the
// retired-store path. Retired stores are queued in a small circular write
// buffer and drained in the background. Loads are issued one at a time.
// A load that hits the word address of a buffered store is held back until
// that store has been written. A load-streak counter stops a steady stream
// of loads from starving the buffer, and a high-water mark stops the buffer
// from starving loads for long.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    cancels the pending/in-flight load; buffer untouched
//   st_valid/st_addr/st_wdata/st_ready   retired-store push interface
//   ld_req/ld_addr/ld_ready  load request, accepted (and issued) when ld_ready
//   ld_rvalid/ld_rdata       load response (raw memory word)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata/mem_rvalid   memory port
//   wb_count/wb_empty        registered write-buffer occupancy / empty flag
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int WB_DEPTH     = 8,
    parameter int WB_HIGH      = 6,
    parameter int MAX_LD_BURST = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          st_valid,
    input  logic [ADDR_WIDTH-1:0]         st_addr,
    input  logic [DATA_WIDTH-1:0]         st_wdata,
    output logic                          st_ready,
    input  logic                          ld_req,
    input  logic [ADDR_WIDTH-1:0]         ld_addr,
    output logic                          ld_ready,
    output logic                          ld_rvalid,
    output logic [DATA_WIDTH-1:0]         ld_rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    input  logic                          mem_rvalid,
    output logic [$clog2(WB_DEPTH):0]     wb_count,
    output logic                          wb_empty
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_LD_BURST + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DROP = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   wb_addr [WB_DEPTH];
    logic [DATA_WIDTH-1:0]   wb_data [WB_DEPTH];
    logic [PW-1:0]           head;
    logic [PW-1:0]           tail;
    logic [CW-1:0]           count;
    logic [SW-1:0]           ld_streak;
    logic [PW-1:0]           rel;
    logic                    hazard;
    logic                    push;
    logic                    st_grant;
    logic                    ld_grant;
    logic                    wb_nonempty;

    assign wb_nonempty = (count != '0);
    assign wb_count    = count;
    assign wb_empty    = !wb_nonempty;
    // Readiness looks only at the registered count, never at a same-cycle pop.
    assign st_ready    = !rst && (count != CW'(WB_DEPTH));
    assign push        = st_valid && st_ready;

    // An entry is valid when its distance from head is below the occupancy.
    // Only the word address matters; byte offsets within a word alias.
    always_comb begin
        hazard = 1'b0;
        rel    = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            rel = PW'(i) - head;
            if ((CW'(rel) < count) &&
                (wb_addr[i][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2])) begin
                hazard = 1'b1;
            end
        end
    end

    // One grant per cycle, IDLE only. Forced store drain beats loads when the
    // buffer is nearly full, when the load aliases a buffered store, or when
    // loads have used up their burst allowance.
    always_comb begin
        st_grant = 1'b0;
        ld_grant = 1'b0;
        if (!rst && state == IDLE) begin
            if (wb_nonempty && ((count >= CW'(WB_HIGH)) || hazard ||
                                (ld_streak == SW'(MAX_LD_BURST)))) begin
                st_grant = 1'b1;
            end else if (ld_req && !flush) begin
                ld_grant = 1'b1;
            end else if (wb_nonempty) begin
                st_grant = 1'b1;
            end
        end
    end

    assign mem_en    = st_grant || ld_grant;
    assign mem_we    = st_grant;
    assign ld_ready  = ld_grant;
    assign mem_addr  = st_grant ? wb_addr[head] : (ld_grant ? ld_addr : '0);
    assign mem_wdata = st_grant ? wb_data[head] : '0;

    // Responses arriving in IDLE or RD_DROP (stale or flushed reads) vanish.
    assign ld_rvalid = !rst && mem_rvalid && (state == RD_WAIT) && !flush;
    assign ld_rdata  = ld_rvalid ? mem_rdata : '0;

    // Buffer storage needs no reset: entries are qualified by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[tail] <= st_addr;
            wb_data[tail] <= st_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (st_grant) begin
                head <= head + PW'(1);
            end
            case ({push, st_grant})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Streak only counts loads that overtook waiting stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_streak <= '0;
        end else if (st_grant) begin
            ld_streak <= '0;
        end else if (ld_grant && wb_nonempty) begin
            if (ld_streak != SW'(MAX_LD_BURST)) begin
                ld_streak <= ld_streak + SW'(1);
            end
        end else if (!wb_nonempty) begin
            ld_streak <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_grant) begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end else if (flush) begin
                        state <= RD_DROP;
                    end
                end
                RD_DROP: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//
// Scoreboard bench for dmem_port_arbiter. Each stimulus step records the
// memory accesses and load responses it should cause, tagged with the exact
// cycle they are due; a negedge monitor compares every cycle of the memory
// port and load-response outputs against the head of those queues.
module tb_dmem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_wdata;
    logic          st_ready;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic          ld_ready;
    logic          ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic [3:0]    wb_count;
    logic          wb_empty;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .WB_DEPTH     (8),
        .WB_HIGH      (6),
        .MAX_LD_BURST (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_wdata   (st_wdata),
        .st_ready   (st_ready),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_ready   (ld_ready),
        .ld_rvalid  (ld_rvalid),
        .ld_rdata   (ld_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .wb_count   (wb_count),
        .wb_empty   (wb_empty)
    );

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rd_exp_t;

    mem_exp_t memQ[$];
    rd_exp_t  rdQ[$];
    mem_exp_t me;
    rd_exp_t  re;
    logic     memHit;
    logic     rdHit;

    int cyc = 0;
    int testsRun = 0;
    int testsFailed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, wanted 0x%0h",
                     tag, cyc, observed, expected);
        end
    endtask

    task automatic expectMem(input int c, input logic we, input logic [31:0] a,
                             input logic [31:0] d);
        mem_exp_t e;
        e.cyc = c; e.we = we; e.addr = a; e.data = d;
        memQ.push_back(e);
    endtask

    task automatic expectRd(input int c, input logic [31:0] d);
        rd_exp_t e;
        e.cyc = c; e.data = d;
        rdQ.push_back(e);
    endtask

    // Drives one cycle of inputs, then advances to just after the next edge.
    task automatic applyStimulus(input logic sv, input logic [31:0] sa,
                                 input logic [31:0] sd, input logic lr,
                                 input logic [31:0] la, input logic fl,
                                 input logic mrv, input logic [31:0] mrd);
        st_valid   = sv;
        st_addr    = sa;
        st_wdata   = sd;
        ld_req     = lr;
        ld_addr    = la;
        flush      = fl;
        mem_rvalid = mrv;
        mem_rdata  = mrd;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    endtask

    // Every cycle: the port must be busy exactly when an access is due.
    always @(negedge clk) begin
        memHit = 1'b0;
        if (memQ.size() > 0) begin
            if (memQ[0].cyc == cyc) memHit = 1'b1;
        end
        checkOutput("mem_en", mem_en, memHit);
        if (memHit) begin
            me = memQ.pop_front();
            checkOutput("mem_we", mem_we, me.we);
            checkOutput("mem_addr", mem_addr, me.addr);
            if (me.we) checkOutput("mem_wdata", mem_wdata, me.data);
            checkOutput("ld_ready", ld_ready, !me.we);
        end else begin
            checkOutput("ld_ready_idle", ld_ready, 0);
            checkOutput("mem_addr_idle", mem_addr, 0);
        end

        rdHit = 1'b0;
        if (rdQ.size() > 0) begin
            if (rdQ[0].cyc == cyc) rdHit = 1'b1;
        end
        checkOutput("ld_rvalid", ld_rvalid, rdHit);
        if (rdHit) begin
            re = rdQ.pop_front();
            checkOutput("ld_rdata", ld_rdata, re.data);
        end else begin
            checkOutput("ld_rdata_idle", ld_rdata, 0);
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int k;
        rst = 1'b1;
        flush = 1'b0; st_valid = 1'b0; st_addr = '0; st_wdata = '0;
        ld_req = 1'b0; ld_addr = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_wb_empty", wb_empty, 1);
        checkOutput("rst_wb_count", wb_count, 0);
        checkOutput("rst_st_ready", st_ready, 0);
        rst = 1'b0;
        idleCycle();

        $display("[TB] store drain");
        c = cyc;
        expectMem(c + 1, 1'b1, 32'h100, 32'hA);
        expectMem(c + 2, 1'b1, 32'h104, 32'hB);
        expectMem(c + 3, 1'b1, 32'h108, 32'hC);
        applyStimulus(1'b1, 32'h100, 32'hA, 1'b0, 0, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 32'h104, 32'hB, 1'b0, 0, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 32'h108, 32'hC, 1'b0, 0, 1'b0, 1'b0, 0);
        idleCycle();
        checkOutput("drain_empty", wb_empty, 1);
        checkOutput("drain_count", wb_count, 0);

        $display("[TB] load with 2-cycle memory");
        c = cyc;
        expectMem(c, 1'b0, 32'h200, 0);
        expectRd(c + 2, 32'hDEADBEEF);
        applyStimulus(1'b0, 0, 0, 1'b1, 32'h200, 1'b0, 1'b0, 0);
        idleCycle();
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hDEADBEEF);
        idleCycle();

        $display("[TB] hazard");
        c = cyc;
        expectMem(c + 1, 1'b1, 32'h300, 32'h33);
        expectMem(c + 2, 1'b0, 32'h302, 0);
        expectRd(c + 3, 32'h12345678);
        applyStimulus(1'b1, 32'h300, 32'h33, 1'b0, 0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b1, 32'h302, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b1, 32'h302, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 32'h12345678);

        $display("[TB] fill and high-water priority");
        c = cyc;
        expectMem(c, 1'b0, 32'h500, 0);
        applyStimulus(1'b0, 0, 0, 1'b1, 32'h500, 1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("fill_st_ready", st_ready, 1);
            applyStimulus(1'b1, 32'h600 + 32'(4 * i), 32'h60 + 32'(i),
                          1'b0, 0, 1'b0, 1'b0, 0);
        end
        checkOutput("full_count", wb_count, 8);
        checkOutput("full_st_ready", st_ready, 0);
        applyStimulus(1'b1, 32'h700, 32'h77, 1'b0, 0, 1'b0, 1'b0, 0);
        checkOutput("drop_count", wb_count, 8);
        expectRd(c + 10, 32'h55);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 32'h55);
        expectMem(c + 11, 1'b1, 32'h600, 32'h60);
        expectMem(c + 12, 1'b1, 32'h604, 32'h61);
        expectMem(c + 13, 1'b1, 32'h608, 32'h62);
        expectMem(c + 14, 1'b0, 32'h800, 0);
        expectRd(c + 16, 32'h88);
        for (int i = 0; i < 5; i++) begin
            expectMem(c + 17 + i, 1'b1, 32'h60C + 32'(4 * i), 32'h63 + 32'(i));
        end
        repeat (4) applyStimulus(1'b0, 0, 0, 1'b1, 32'h800, 1'b0, 1'b0, 0);
        idleCycle();
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 32'h88);
        repeat (5) idleCycle();
        checkOutput("refill_empty", wb_empty, 1);

        $display("[TB] load burst limit");
        c = cyc;
        expectMem(c, 1'b0, 32'hA00, 0);
        expectRd(c + 1, 32'hD0);
        for (int j = 1; j <= 4; j++) begin
            expectMem(c + 2 * j, 1'b0, 32'hA00 + 32'(4 * j), 0);
            expectRd(c + 2 * j + 1, 32'hD0 + 32'(j));
        end
        expectMem(c + 10, 1'b1, 32'h900, 32'h99);
        expectMem(c + 11, 1'b0, 32'hA14, 0);
        expectRd(c + 12, 32'hD5);
        applyStimulus(1'b1, 32'h900, 32'h99, 1'b1, 32'hA00, 1'b0, 1'b0, 0);
        for (int o = 1; o <= 11; o++) begin
            k = (o + 1) / 2;
            if (k > 5) k = 5;
            applyStimulus(1'b0, 0, 0, 1'b1, 32'hA00 + 32'(4 * k), 1'b0,
                          ((o % 2) == 1) && (o <= 9), 32'hD0 + 32'((o - 1) / 2));
        end
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hD5);

        $display("[TB] flush");
        c = cyc;
        expectMem(c, 1'b0, 32'hB00, 0);
        expectMem(c + 5, 1'b1, 32'h400, 32'h44);
        expectMem(c + 7, 1'b0, 32'hC00, 0);
        expectMem(c + 9, 1'b0, 32'hC08, 0);
        expectRd(c + 10, 32'hCC);
        applyStimulus(1'b1, 32'h400, 32'h44, 1'b1, 32'hB00, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0, 0);
        idleCycle();
        idleCycle();
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hBAD);
        applyStimulus(1'b0, 0, 0, 1'b1, 32'hC00, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b1, 32'hC00, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b1, 32'hC00, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1, 32'hBBB);
        applyStimulus(1'b0, 0, 0, 1'b1, 32'hC08, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hCC);

        $display("[TB] reset mid-read");
        c = cyc;
        expectMem(c, 1'b0, 32'hF00, 0);
        applyStimulus(1'b1, 32'hE00, 32'hE0, 1'b1, 32'hF00, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 32'hE04, 32'hE4, 1'b0, 0, 1'b0, 1'b0, 0);
        checkOutput("pre_rst_count", wb_count, 2);
        rst = 1'b1;
        st_valid = 1'b1; st_addr = 32'hE08; st_wdata = 32'hE8;
        ld_req = 1'b1; ld_addr = 32'hF04;
        #1;
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_ld_ready", ld_ready, 0);
        checkOutput("rst_st_ready2", st_ready, 0);
        checkOutput("rst_ld_rvalid", ld_rvalid, 0);
        checkOutput("rst_count2", wb_count, 0);
        checkOutput("rst_empty2", wb_empty, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycle();
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hFFF);
        idleCycle();
        checkOutput("post_rst_count", wb_count, 0);
        checkOutput("post_rst_empty", wb_empty, 1);
        idleCycle();

        checkOutput("memq_left", memQ.size(), 0);
        checkOutput("rdq_left", rdQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
